audio_sram_arbiter: RTL

//  Shares the single 1Mx16 external SRAM between the recorder write stream and the player read stream.

---
 rtl/audio_sram_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/audio_sram_arbiter.sv
// audio_sram_arbiter: shares one external SRAM between recorder writes and player reads.
// Define REC_PRIORITY_EN for fixed recorder priority instead of round-robin arbitration.
module audio_sram_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rec_req,
    input  logic [AW-1:0] i_rec_addr,
    input  logic [DW-1:0] i_rec_wdata,
    output logic          o_rec_ack,
    input  logic          i_play_req,
    input  logic [AW-1:0] i_play_addr,
    output logic          o_play_ack,
    output logic [DW-1:0] o_play_rdata,
    output logic          o_busy,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_dq,
    output logic          o_sram_dq_oe,
    input  logic [DW-1:0] i_sram_dq,
    output logic          o_sram_we_n,
    output logic          o_sram_ce_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_lb_n,
    output logic          o_sram_ub_n
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);
    state_t     state;
    logic [3:0] acc_cnt;
    logic       rec_win;
`ifdef REC_PRIORITY_EN
    assign rec_win = i_rec_req;
`else
    logic rr_play;
    assign rec_win = i_rec_req && !(i_play_req && rr_play);
    // after each grant the pointer favours the requester that did not win
    always_ff @(posedge i_clk) begin
        if (i_rst)
            rr_play <= 1'b0;
        else if (state == IDLE && (i_rec_req || i_play_req))
            rr_play <= rec_win;
    end
`endif
    // access sequencer: grant in IDLE, hold strobes for ACC_CYCLES, then one idle turnaround cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            o_rec_ack    <= 1'b0;
            o_play_ack   <= 1'b0;
            o_play_rdata <= '0;
            o_busy       <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_sram_dq_oe <= 1'b0;
            o_sram_we_n  <= 1'b1;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
        end else begin
            o_rec_ack  <= 1'b0;
            o_play_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rec_req || i_play_req) begin
                        state        <= rec_win ? WRITE : READ;
                        acc_cnt      <= ACC_LAST;
                        o_sram_addr  <= rec_win ? i_rec_addr : i_play_addr;
                        o_sram_dq    <= rec_win ? i_rec_wdata : o_sram_dq;
                        o_sram_dq_oe <= rec_win;
                        o_sram_we_n  <= !rec_win;
                        o_sram_oe_n  <= rec_win;
                        o_sram_ce_n  <= 1'b0;
                        o_sram_lb_n  <= 1'b0;
                        o_sram_ub_n  <= 1'b0;
                        o_busy       <= 1'b1;
                        o_rec_ack    <= rec_win && (ACC_LAST == 4'd0);
                    end
                end
                default: begin
                    acc_cnt <= acc_cnt - 4'd1;
                    if (acc_cnt == 4'd0) begin
                        state        <= IDLE;
                        o_busy       <= 1'b0;
                        o_sram_dq_oe <= 1'b0;
                        o_sram_we_n  <= 1'b1;
                        o_sram_ce_n  <= 1'b1;
                        o_sram_oe_n  <= 1'b1;
                        o_sram_lb_n  <= 1'b1;
                        o_sram_ub_n  <= 1'b1;
                        o_play_rdata <= (state == READ) ? i_sram_dq : o_play_rdata;
                        o_play_ack   <= (state == READ);
                    end else begin
                        o_rec_ack <= (state == WRITE) && (acc_cnt == 4'd1);
                    end
                end
            endcase
        end
    end
endmodule
